// File: rtl/fpu_ss_prd_arbiter.sv
// Round-robin arbiter sharing one predecoder among NumReq requesters, with a held response register.
// Optional grant statistics counters are enabled by defining FPU_SS_PRD_ARB_STATS_EN.
module fpu_ss_prd_arbiter #(
   parameter int unsigned NumReq     = 2,
   parameter int unsigned InstrWidth = 32
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NumReq-1:0]            q_valid_i,
   output logic [NumReq-1:0]            q_ready_o,
   input  logic [NumReq*InstrWidth-1:0] q_instr_i,
   output logic [NumReq-1:0]            p_valid_o,
   input  logic [NumReq-1:0]            p_ready_i,
   output logic                         p_accept_o,
   output logic                         p_writeback_o,
   output logic                         p_is_mem_op_o,
   output logic [2:0]                   p_use_rs_o,
   output logic [InstrWidth-1:0]        prd_instr_o,
   input  logic                         prd_accept_i,
   input  logic                         prd_writeback_i,
   input  logic                         prd_is_mem_op_i,
   input  logic [2:0]                   prd_use_rs_i
`ifdef FPU_SS_PRD_ARB_STATS_EN
   ,
   output logic [15:0]                  stat_acc_o,
   output logic [15:0]                  stat_rej_o
`endif
);

   localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

   typedef enum logic {IDLE, RESP} state_e;

   state_e                state;
   logic [IdxW-1:0]       rr_q;
   logic [IdxW-1:0]       owner;
   logic [IdxW-1:0]       winner;
   logic [IdxW-1:0]       idx;
   logic                  found;
   logic                  can_grant;
   logic                  grant;
   logic [InstrWidth-1:0] instr_arr [NumReq];

   for (genvar g = 0; g < NumReq; g++) begin : g_unpack
      assign instr_arr[g] = q_instr_i[g*InstrWidth +: InstrWidth];
   end

   // First valid requester in search order starting at rr_q.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int i = 0; i < int'(NumReq); i++) begin
         idx = IdxW'((int'(rr_q) + i) % int'(NumReq));
         if (!found && q_valid_i[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   assign can_grant   = (state == IDLE) || p_ready_i[owner];
   assign grant       = can_grant && found && !rst_i;
   assign q_ready_o   = grant ? (NumReq'(1) << winner) : '0;
   assign prd_instr_o = grant ? instr_arr[winner] : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= IDLE;
         rr_q          <= '0;
         owner         <= '0;
         p_valid_o     <= '0;
         p_accept_o    <= 1'b0;
         p_writeback_o <= 1'b0;
         p_is_mem_op_o <= 1'b0;
         p_use_rs_o    <= 3'b000;
`ifdef FPU_SS_PRD_ARB_STATS_EN
         stat_acc_o    <= 16'h0000;
         stat_rej_o    <= 16'h0000;
`endif
      end else if (grant) begin
         state         <= RESP;
         owner         <= winner;
         rr_q          <= IdxW'((int'(winner) + 1) % int'(NumReq));
         p_valid_o     <= NumReq'(1) << winner;
         p_accept_o    <= prd_accept_i;
         p_writeback_o <= prd_writeback_i;
         p_is_mem_op_o <= prd_is_mem_op_i;
         p_use_rs_o    <= prd_use_rs_i;
`ifdef FPU_SS_PRD_ARB_STATS_EN
         if (prd_accept_i) begin
            if (stat_acc_o != 16'hFFFF) stat_acc_o <= stat_acc_o + 16'd1;
         end else begin
            if (stat_rej_o != 16'hFFFF) stat_rej_o <= stat_rej_o + 16'd1;
         end
`endif
      end else if (state == RESP && p_ready_i[owner]) begin
         // Response fields are kept; only the valid is withdrawn.
         state     <= IDLE;
         p_valid_o <= '0;
      end
   end

endmodule

// File: tb/tb_fpu_ss_prd_arbiter.sv
// Directed table-driven bench for fpu_ss_prd_arbiter (NumReq=2), plus a fairness sequence.
// Statistics checks are compiled in when FPU_SS_PRD_ARB_STATS_EN is defined.
module tb_fpu_ss_prd_arbiter;

   localparam int unsigned NumReq     = 2;
   localparam int unsigned InstrWidth = 32;

   logic                         clk_i;
   logic                         rst_i;
   logic [NumReq-1:0]            q_valid_i;
   logic [NumReq-1:0]            q_ready_o;
   logic [NumReq*InstrWidth-1:0] q_instr_i;
   logic [NumReq-1:0]            p_valid_o;
   logic [NumReq-1:0]            p_ready_i;
   logic                         p_accept_o;
   logic                         p_writeback_o;
   logic                         p_is_mem_op_o;
   logic [2:0]                   p_use_rs_o;
   logic [InstrWidth-1:0]        prd_instr_o;
   logic                         prd_accept_i;
   logic                         prd_writeback_i;
   logic                         prd_is_mem_op_i;
   logic [2:0]                   prd_use_rs_i;
`ifdef FPU_SS_PRD_ARB_STATS_EN
   logic [15:0]                  stat_acc_o;
   logic [15:0]                  stat_rej_o;
`endif

   fpu_ss_prd_arbiter #(.NumReq(NumReq), .InstrWidth(InstrWidth)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .q_valid_i       (q_valid_i),
      .q_ready_o       (q_ready_o),
      .q_instr_i       (q_instr_i),
      .p_valid_o       (p_valid_o),
      .p_ready_i       (p_ready_i),
      .p_accept_o      (p_accept_o),
      .p_writeback_o   (p_writeback_o),
      .p_is_mem_op_o   (p_is_mem_op_o),
      .p_use_rs_o      (p_use_rs_o),
      .prd_instr_o     (prd_instr_o),
      .prd_accept_i    (prd_accept_i),
      .prd_writeback_i (prd_writeback_i),
      .prd_is_mem_op_i (prd_is_mem_op_i),
      .prd_use_rs_i    (prd_use_rs_i)
`ifdef FPU_SS_PRD_ARB_STATS_EN
      ,
      .stat_acc_o      (stat_acc_o),
      .stat_rej_o      (stat_rej_o)
`endif
   );

   localparam logic [31:0] Instr0 = 32'hAAAA_0000;
   localparam logic [31:0] Instr1 = 32'hBBBB_1111;

   typedef struct {
      logic       rst;
      logic [1:0] qv;
      logic [1:0] pr;
      logic [5:0] prd;     // {accept, writeback, is_mem_op, use_rs[2:0]}
      logic [1:0] exp_qr;
      logic [1:0] exp_pv;
      logic [5:0] exp_fld;
   } vec_t;

   vec_t vecs [21];
   int   checks = 0;
   int   errors = 0;
   int   exp_acc = 0;
   int   exp_rej = 0;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_instr(input logic [1:0] qr);
      case (qr)
         2'b01:   return Instr0;
         2'b10:   return Instr1;
         default: return 32'h0;
      endcase
   endfunction

   task automatic stats_model(input logic rst, input logic [1:0] qr, input logic acc);
      if (rst) begin
         exp_acc = 0;
         exp_rej = 0;
      end else if (qr != 2'b00) begin
         if (acc) exp_acc++;
         else     exp_rej++;
      end
   endtask

   initial begin
      //          rst  qv     pr     prd        exp_qr exp_pv exp_fld
      vecs[0]  = '{1'b1, 2'b11, 2'b11, 6'b100011, 2'b00, 2'b00, 6'b000000};
      vecs[1]  = '{1'b0, 2'b01, 2'b11, 6'b110011, 2'b01, 2'b01, 6'b110011};
      vecs[2]  = '{1'b0, 2'b00, 2'b11, 6'b000000, 2'b00, 2'b00, 6'b110011};
      vecs[3]  = '{1'b0, 2'b11, 2'b11, 6'b101101, 2'b10, 2'b10, 6'b101101};
      vecs[4]  = '{1'b0, 2'b11, 2'b11, 6'b000000, 2'b01, 2'b01, 6'b000000};
      vecs[5]  = '{1'b0, 2'b11, 2'b11, 6'b111111, 2'b10, 2'b10, 6'b111111};
      vecs[6]  = '{1'b0, 2'b11, 2'b01, 6'b000000, 2'b00, 2'b10, 6'b111111};
      vecs[7]  = '{1'b0, 2'b11, 2'b00, 6'b000000, 2'b00, 2'b10, 6'b111111};
      vecs[8]  = '{1'b0, 2'b11, 2'b01, 6'b000000, 2'b00, 2'b10, 6'b111111};
      vecs[9]  = '{1'b0, 2'b11, 2'b00, 6'b000000, 2'b00, 2'b10, 6'b111111};
      vecs[10] = '{1'b0, 2'b11, 2'b01, 6'b000000, 2'b00, 2'b10, 6'b111111};
      vecs[11] = '{1'b0, 2'b11, 2'b10, 6'b100010, 2'b01, 2'b01, 6'b100010};
      vecs[12] = '{1'b0, 2'b00, 2'b01, 6'b000000, 2'b00, 2'b00, 6'b100010};
      vecs[13] = '{1'b0, 2'b10, 2'b00, 6'b000000, 2'b10, 2'b10, 6'b000000};
      vecs[14] = '{1'b0, 2'b10, 2'b10, 6'b110001, 2'b10, 2'b10, 6'b110001};
      vecs[15] = '{1'b0, 2'b01, 2'b10, 6'b011110, 2'b01, 2'b01, 6'b011110};
      vecs[16] = '{1'b0, 2'b10, 2'b01, 6'b100000, 2'b10, 2'b10, 6'b100000};
      vecs[17] = '{1'b1, 2'b11, 2'b00, 6'b111111, 2'b00, 2'b00, 6'b000000};
      vecs[18] = '{1'b0, 2'b11, 2'b00, 6'b100100, 2'b01, 2'b01, 6'b100100};
      vecs[19] = '{1'b0, 2'b11, 2'b00, 6'b111111, 2'b00, 2'b01, 6'b100100};
      vecs[20] = '{1'b0, 2'b11, 2'b01, 6'b000000, 2'b10, 2'b10, 6'b000000};

      rst_i     = 1'b1;
      q_valid_i = '0;
      p_ready_i = '0;
      q_instr_i = {Instr1, Instr0};
      {prd_accept_i, prd_writeback_i, prd_is_mem_op_i, prd_use_rs_i} = 6'b000000;

      for (int i = 0; i < 21; i++) begin
         @(negedge clk_i);
         rst_i     = vecs[i].rst;
         q_valid_i = vecs[i].qv;
         p_ready_i = vecs[i].pr;
         {prd_accept_i, prd_writeback_i, prd_is_mem_op_i, prd_use_rs_i} = vecs[i].prd;
         #1;
         check($sformatf("q_ready[%0d]", i), 32'(q_ready_o), 32'(vecs[i].exp_qr));
         check($sformatf("prd_instr[%0d]", i), prd_instr_o, exp_instr(vecs[i].exp_qr));
         stats_model(vecs[i].rst, vecs[i].exp_qr, vecs[i].prd[5]);
         @(posedge clk_i);
         #1;
         check($sformatf("p_valid[%0d]", i), 32'(p_valid_o), 32'(vecs[i].exp_pv));
         check($sformatf("p_fields[%0d]", i),
               32'({p_accept_o, p_writeback_o, p_is_mem_op_o, p_use_rs_o}), 32'(vecs[i].exp_fld));
`ifdef FPU_SS_PRD_ARB_STATS_EN
         check($sformatf("stat_acc[%0d]", i), 32'(stat_acc_o), 32'(exp_acc));
         check($sformatf("stat_rej[%0d]", i), 32'(stat_rej_o), 32'(exp_rej));
`endif
      end

      // Fairness: owner is 1 and rr points to 0, so grants alternate starting at 0.
      for (int k = 0; k < 6; k++) begin
         @(negedge clk_i);
         q_valid_i = 2'b11;
         p_ready_i = 2'b11;
         {prd_accept_i, prd_writeback_i, prd_is_mem_op_i, prd_use_rs_i} = 6'(k);
         #1;
         check($sformatf("fair_q_ready[%0d]", k), 32'(q_ready_o), (k % 2 == 0) ? 32'h1 : 32'h2);
         stats_model(1'b0, 2'b01, 1'b0);
         @(posedge clk_i);
         #1;
         check($sformatf("fair_p_valid[%0d]", k), 32'(p_valid_o), (k % 2 == 0) ? 32'h1 : 32'h2);
         check($sformatf("fair_fields[%0d]", k), 32'({p_accept_o, p_writeback_o, p_is_mem_op_o, p_use_rs_o}), 32'(k));
      end

`ifdef FPU_SS_PRD_ARB_STATS_EN
      // Saturation: reset, then 65537 accepted grants from requester 0.
      @(negedge clk_i);
      rst_i     = 1'b1;
      q_valid_i = 2'b01;
      p_ready_i = 2'b11;
      {prd_accept_i, prd_writeback_i, prd_is_mem_op_i, prd_use_rs_i} = 6'b100000;
      @(negedge clk_i);
      rst_i = 1'b0;
      repeat (65537) @(posedge clk_i);
      #1;
      check("stat_acc_sat", 32'(stat_acc_o), 32'h0000FFFF);
      check("stat_rej_sat", 32'(stat_rej_o), 32'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
